// File: rtl/pc_gen_pkg.sv
// Shared helpers for the fetch front end: thread-index sizing and rotate-priority distance.
// Pure constants and functions; no state, no latency, no handshake.
// Backpressure: not applicable.
package pc_gen_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scan distance of index j from cur in an n-entry ring; cur itself is the last candidate.
    function automatic int rr_dist(input int j, input int cur, input int n);
        int d;
        d = (j + n - cur) % n;
        return (d == 0) ? n : d;
    endfunction

endpackage

// File: rtl/pc_gen_mt_if.sv
// Fetch-request and redirect bundle between branch/trap resolution, pc_gen_mt and fetch.
// Wires only; no latency.
// Backpressure: out_ready stalls the presented request.
interface pc_gen_mt_if #(
    parameter int PC_WIDTH = 32,
    parameter int TID_W    = 2
);
    logic                redirect_valid;
    logic [TID_W-1:0]    redirect_tid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                redirect_misalign;
    logic                out_valid;
    logic                out_ready;
    logic [TID_W-1:0]    out_tid;
    logic [PC_WIDTH-1:0] out_pc;

    modport master (
        input  redirect_valid, redirect_tid, redirect_pc, out_ready,
        output redirect_misalign, out_valid, out_tid, out_pc
    );

    modport slave (
        output redirect_valid, redirect_tid, redirect_pc, out_ready,
        input  redirect_misalign, out_valid, out_tid, out_pc
    );
endinterface

// File: rtl/pc_gen_mt_rr_next_sel.sv
// Rotate-priority finder: first set bit of en after cur, wrapping back to cur.
// Combinational, zero latency.
// Backpressure: none; nxt holds cur when no bit is set.
module rr_next_sel
    import pc_gen_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     en,
    input  logic [IDX_W-1:0] cur,
    output logic [IDX_W-1:0] nxt,
    output logic             any
);

    always_comb begin
        int best;
        nxt  = cur;
        best = N + 1;
        for (int j = 0; j < N; j++) begin
            if (en[j] && (rr_dist(j, int'(cur), N) < best)) begin
                best = rr_dist(j, int'(cur), N);
                nxt  = IDX_W'(j);
            end
        end
    end

    assign any = |en;

endmodule

// File: rtl/pc_gen_mt.sv
// Multi-thread PC generator: one {tid, pc} fetch request per cycle, round-robin over enabled threads.
// Redirect/increment visible one cycle after the edge; outputs combinational from state.
// Backpressure: out_ready low holds sel and PC; redirect to sel or halting sel still take effect.
module pc_gen_mt
    import pc_gen_pkg::*;
#(
    parameter int PC_WIDTH            = 32,
    parameter int PC_INC              = 4,
    parameter int NUM_THREADS         = 4,
    parameter int PC_RESET_VAL        = 0,
    parameter int THREAD_RESET_STRIDE = 'h100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_THREADS-1:0] thread_en,
    pc_gen_mt_if.master            bus
);

    localparam int TID_W = clog2_min1(NUM_THREADS);
    localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(PC_INC);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(PC_INC - 1));

    function automatic logic [PC_WIDTH-1:0] reset_pc(input int t);
        return PC_WIDTH'(PC_RESET_VAL) + PC_WIDTH'(t) * PC_WIDTH'(THREAD_RESET_STRIDE);
    endfunction

    logic [PC_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [TID_W-1:0]    sel_q;
    logic                misalign_q;

    logic                sel_vld;
    logic                fire;
    logic                redir_ok;
    logic [TID_W-1:0]    nxt_sel;
    logic                any_en;

    rr_next_sel #(
        .N     (NUM_THREADS),
        .IDX_W (TID_W)
    ) u_rr (
        .en  (thread_en),
        .cur (sel_q),
        .nxt (nxt_sel),
        .any (any_en)
    );

    assign sel_vld  = thread_en[sel_q];
    assign fire     = sel_vld & bus.out_ready;
    assign redir_ok = bus.redirect_valid & (32'(bus.redirect_tid) < NUM_THREADS);

    // rst_n gates only the output so the request drops the instant reset asserts.
    assign bus.out_valid         = rst_n & sel_vld;
    assign bus.out_tid           = sel_q;
    assign bus.out_pc            = pc_q[sel_q];
    assign bus.redirect_misalign = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= reset_pc(t);
            end
            sel_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            // Redirect beats the increment; the old PC still counts as fetched.
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redir_ok && (bus.redirect_tid == TID_W'(t))) begin
                    pc_q[t] <= bus.redirect_pc & ALIGN_MASK;
                end else if (fire && (sel_q == TID_W'(t))) begin
                    pc_q[t] <= pc_q[t] + INC;
                end
            end
            misalign_q <= redir_ok & (|(bus.redirect_pc & ~ALIGN_MASK));
            if ((fire || !sel_vld) && any_en) begin
                sel_q <= nxt_sel;
            end
        end
    end

endmodule
